imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_if.sv | 51 +++++
 rtl/imem_arbiter.sv | 124 ++++++++++++
 tb/tb_imem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// Instruction-memory arbiter bus bundle: fetch port, loader port and the
// single-ported RAM side. The "slave" modport is the arbiter itself; the
// "master" modport is the environment (fetch unit, loader and RAM model).
// Width defaults fall back to local values when `ADDRWIDTH/`DATAWIDTH are
// not supplied by the surrounding build.

`ifndef ADDRWIDTH
`define ADDRWIDTH 12
`endif
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif

interface imem_arbiter_if #(
  parameter int ADDR_W = `ADDRWIDTH,
  parameter int DATA_W = `DATAWIDTH
);
  // fetch port
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_flush;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  // loader / debug port
  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;
  // memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, f_flush, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, f_flush, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one registered-address RAM between the
// instruction fetch port and a loader/debug port. Fetch has priority; the
// loader gets the RAM whenever fetch is idle.
//
// Optional feature, macro IMEM_ARB_STARVE_EN: when defined, a saturating
// starvation counter forces one loader grant after STARVE_MAX consecutive
// denied loader cycles. When undefined, fetch priority is strict.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access granted last cycle, no response due
// FETCH | fetch read granted last cycle, fetch response due now
// LRD   | loader read granted last cycle, loader response due now
// LWR   | loader write granted last cycle, nothing to return
//
// Reset is synchronous, active-low; grants and responses are also gated by
// rst_n so everything reads 0 while reset is held.

`ifndef ADDRWIDTH
`define ADDRWIDTH 12
`endif
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif

module imem_arbiter #(
  parameter int ADDR_W     = `ADDRWIDTH,
  parameter int DATA_W     = `DATAWIDTH,
  parameter int STARVE_MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LRD   = 2'd2,
    LWR   = 2'd3
  } state_t;

  // STARVE_MAX must fit the 8-bit counter and be non-zero
  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("imem_arbiter: STARVE_MAX must be in 1..255");
  end

  state_t            r_state;
  logic              w_f_gnt;
  logic              w_l_gnt;
  logic              w_starve_hit;
  logic              w_f_rvalid;
  logic              w_l_rvalid;

`ifdef IMEM_ARB_STARVE_EN
  localparam logic [7:0] LP_STARVE_MAX = 8'(STARVE_MAX);

  logic [7:0] r_starve_cnt;

  assign w_starve_hit = (r_starve_cnt == LP_STARVE_MAX);

  // count consecutive denied loader cycles, saturating; any grant or a
  // dropped request restarts the count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve_cnt <= 8'd0;
    end else if (!bus.l_req || w_l_gnt) begin
      r_starve_cnt <= 8'd0;
    end else if (r_starve_cnt < LP_STARVE_MAX) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end
`else
  assign w_starve_hit = 1'b0;
`endif

  // grant decision: fetch by default, loader when fetch is idle or starved
  always_comb begin
    w_l_gnt = rst_n & bus.l_req & (~bus.f_req | w_starve_hit);
    w_f_gnt = rst_n & bus.f_req & ~w_l_gnt;
  end

  // drive the RAM from whichever port won; bus is parked at 0 otherwise
  always_comb begin
    bus.f_gnt     = w_f_gnt;
    bus.l_gnt     = w_l_gnt;
    bus.mem_en    = w_f_gnt | w_l_gnt;
    bus.mem_we    = w_l_gnt & bus.l_we;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (w_l_gnt) begin
      bus.mem_addr  = bus.l_addr;
      bus.mem_wdata = bus.l_wdata;
    end else if (w_f_gnt) begin
      bus.mem_addr  = bus.f_addr;
      bus.mem_wdata = '0;
    end
  end

  // remember what was granted so the RAM output can be routed next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (w_l_gnt) begin
      r_state <= bus.l_we ? LWR : LRD;
    end else if (w_f_gnt) begin
      r_state <= FETCH;
    end else begin
      r_state <= IDLE;
    end
  end

  // route the RAM read data to the owner; a flush kills only the response
  // landing this cycle, never a new request, and idle lanes read as 0
  always_comb begin
    w_f_rvalid   = rst_n & (r_state == FETCH) & ~bus.f_flush;
    w_l_rvalid   = rst_n & (r_state == LRD);
    bus.f_rvalid = w_f_rvalid;
    bus.l_rvalid = w_l_rvalid;
    bus.f_rdata  = w_f_rvalid ? bus.mem_rdata : '0;
    bus.l_rdata  = w_l_rvalid ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (grant rule, pending response, shadow
// memory). Build with +define+IMEM_ARB_STARVE_EN to cover the starvation path.

module tb_imem_arbiter;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int SMAX = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  imem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // registered-address RAM model, preloaded with word i at address i
  logic [DW-1:0] ram    [0:255];
  logic [DW-1:0] shadow [0:255];

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = DW'(i);
      shadow[i] = DW'(i);
    end
    bus.mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  task automatic drive_idle();
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.f_flush = 1'b0;
    bus.l_req   = 1'b0;
    bus.l_we    = 1'b0;
    bus.l_addr  = '0;
    bus.l_wdata = '0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 8'h03;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 8'h03; bus.l_wdata = 32'h1234_5678;
    @(negedge clk);
    n_cmp++;
    if ({bus.f_gnt, bus.l_gnt, bus.mem_en, bus.mem_we, bus.f_rvalid, bus.l_rvalid} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {bus.f_gnt, bus.l_gnt, bus.mem_en, bus.mem_we, bus.f_rvalid, bus.l_rvalid});
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_wdata, bus.f_rdata, bus.l_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_buses: addr=%h wdata=%h frd=%h lrd=%h expected all 0",
               bus.mem_addr, bus.mem_wdata, bus.f_rdata, bus.l_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if ({bus.f_rvalid, bus.l_rvalid} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_exit_rvalid: got %b expected 00", {bus.f_rvalid, bus.l_rvalid});
    end
  endtask

  task automatic test_fetch_burst();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      drive_idle();
      bus.f_req  = (k < 3);
      bus.f_addr = AW'(4 + k);
      @(negedge clk);
      n_cmp++;
      if (bus.f_gnt !== (k < 3) || bus.l_gnt !== 1'b0) begin
        n_err++;
        $display("FAIL burst_gnt k=%0d: f_gnt=%b l_gnt=%b expected %b 0", k, bus.f_gnt, bus.l_gnt, k < 3);
      end
      if (k < 3) begin
        n_cmp++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== AW'(4 + k)) begin
          n_err++;
          $display("FAIL burst_mem k=%0d: en=%b we=%b addr=%h expected 1 0 %h",
                   k, bus.mem_en, bus.mem_we, bus.mem_addr, 4 + k);
        end
      end
      n_cmp++;
      if (bus.f_rvalid !== (k >= 1 && k <= 3) ||
          bus.f_rdata  !== ((k >= 1 && k <= 3) ? DW'(3 + k) : '0) || bus.l_rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL burst_resp k=%0d: f_rvalid=%b f_rdata=%h l_rvalid=%b expected %b %h 0",
                 k, bus.f_rvalid, bus.f_rdata, bus.l_rvalid, (k >= 1 && k <= 3),
                 (k >= 1 && k <= 3) ? 3 + k : 0);
      end
    end
  endtask

  task automatic test_loader();
    @(posedge clk); #1;
    drive_idle();
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 8'h10; bus.l_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if (bus.l_gnt !== 1'b1 || bus.f_gnt !== 1'b0 || bus.mem_we !== 1'b1 ||
        bus.mem_addr !== 8'h10 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL loader_write: l_gnt=%b f_gnt=%b we=%b addr=%h wdata=%h expected 1 0 1 10 deadbeef",
               bus.l_gnt, bus.f_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    shadow[8'h10] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.l_we = 1'b0; bus.l_wdata = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.l_gnt !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_en !== 1'b1 ||
        bus.l_rvalid !== 1'b0 || bus.f_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL loader_read_issue: l_gnt=%b we=%b en=%b l_rvalid=%b f_rvalid=%b expected 1 0 1 0 0",
               bus.l_gnt, bus.mem_we, bus.mem_en, bus.l_rvalid, bus.f_rvalid);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if (bus.l_rvalid !== 1'b1 || bus.l_rdata !== 32'hDEAD_BEEF || bus.f_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL loader_read_data: l_rvalid=%b l_rdata=%h f_rvalid=%b expected 1 deadbeef 0",
               bus.l_rvalid, bus.l_rdata, bus.f_rvalid);
    end
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    drive_idle();
    bus.f_req = 1'b1; bus.f_addr = 8'h07;
    @(negedge clk);
    n_cmp++;
    if (bus.f_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL flush_first_gnt: got %b expected 1", bus.f_gnt);
    end
    @(posedge clk); #1;
    bus.f_flush = 1'b1; bus.f_addr = 8'h08;
    @(negedge clk);
    n_cmp++;
    if (bus.f_gnt !== 1'b1 || bus.f_rvalid !== 1'b0 || bus.f_rdata !== '0) begin
      n_err++;
      $display("FAIL flush_cycle: f_gnt=%b f_rvalid=%b f_rdata=%h expected 1 0 0",
               bus.f_gnt, bus.f_rvalid, bus.f_rdata);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== 32'd8) begin
      n_err++;
      $display("FAIL flush_next_resp: f_rvalid=%b f_rdata=%h expected 1 8", bus.f_rvalid, bus.f_rdata);
    end
  endtask

  // both ports requesting continuously: under starvation control the loader
  // wins exactly every (SMAX+1)th cycle, otherwise never
  task automatic test_priority();
    for (int k = 0; k < 2 * (SMAX + 1); k++) begin
      bit exp_l;
      @(posedge clk); #1;
      bus.f_req = 1'b1; bus.f_addr = AW'(k); bus.f_flush = 1'b0;
      bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 8'h20; bus.l_wdata = '0;
`ifdef IMEM_ARB_STARVE_EN
      exp_l = ((k % (SMAX + 1)) == SMAX);
`else
      exp_l = 1'b0;
`endif
      @(negedge clk);
      n_cmp++;
      if (bus.l_gnt !== exp_l || bus.f_gnt !== !exp_l) begin
        n_err++;
        $display("FAIL priority k=%0d: l_gnt=%b f_gnt=%b expected %b %b", k, bus.l_gnt, bus.f_gnt, exp_l, !exp_l);
      end
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_reset_mid();
    // partially build up loader starvation, then grant a fetch and reset
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      bus.f_req = 1'b1; bus.f_addr = 8'h05; bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 8'h21;
    end
    @(negedge clk);
    n_cmp++;
    if (bus.f_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_gnt: f_gnt=%b expected 1", bus.f_gnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.f_gnt, bus.l_gnt, bus.mem_en, bus.mem_we, bus.f_rvalid, bus.l_rvalid} !== 6'b0 ||
        {bus.mem_addr, bus.mem_wdata, bus.f_rdata, bus.l_rdata} !== '0) begin
      n_err++;
      $display("FAIL rstmid_outputs: strobes=%b addr=%h frd=%h expected 0 0 0",
               {bus.f_gnt, bus.l_gnt, bus.mem_en, bus.mem_we, bus.f_rvalid, bus.l_rvalid},
               bus.mem_addr, bus.f_rdata);
    end
    // after reset the starvation count must restart from zero
    for (int k = 0; k < SMAX + 1; k++) begin
      bit exp_l;
      @(posedge clk); #1;
      rst_n = 1'b1;
`ifdef IMEM_ARB_STARVE_EN
      exp_l = (k == SMAX);
`else
      exp_l = 1'b0;
`endif
      @(negedge clk);
      if (k == 0) begin
        n_cmp++;
        if (bus.f_rvalid !== 1'b0 || bus.l_rvalid !== 1'b0) begin
          n_err++;
          $display("FAIL rstmid_no_resp: f_rvalid=%b l_rvalid=%b expected 0 0", bus.f_rvalid, bus.l_rvalid);
        end
      end
      n_cmp++;
      if (bus.l_gnt !== exp_l) begin
        n_err++;
        $display("FAIL rstmid_starve k=%0d: l_gnt=%b expected %b", k, bus.l_gnt, exp_l);
      end
    end
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
  endtask

  // random traffic against a transaction-level model
  task automatic test_random();
    int            pend_kind = 0;   // 0 none, 1 fetch read, 2 loader read
    logic [DW-1:0] pend_data = '0;
    int            denied    = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit            e_fg, e_lg, e_frv, e_lrv;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata, e_frd, e_lrd;
      @(posedge clk); #1;
      bus.f_req   = ($urandom_range(3, 0) != 0);
      bus.f_addr  = AW'($urandom_range(255, 0));
      bus.f_flush = ($urandom_range(4, 0) == 0);
      bus.l_req   = $urandom_range(1, 0) != 0;
      bus.l_we    = $urandom_range(1, 0) != 0;
      bus.l_addr  = AW'($urandom_range(255, 0));
      bus.l_wdata = $urandom;
`ifdef IMEM_ARB_STARVE_EN
      e_lg = bus.l_req && (!bus.f_req || denied == SMAX);
`else
      e_lg = bus.l_req && !bus.f_req;
`endif
      e_fg    = bus.f_req && !e_lg;
      e_addr  = e_lg ? bus.l_addr : (e_fg ? bus.f_addr : '0);
      e_wdata = e_lg ? bus.l_wdata : '0;
      e_frv   = (pend_kind == 1) && !bus.f_flush;
      e_lrv   = (pend_kind == 2);
      e_frd   = e_frv ? pend_data : '0;
      e_lrd   = e_lrv ? pend_data : '0;
      @(negedge clk);
      n_cmp++;
      if (bus.f_gnt !== e_fg || bus.l_gnt !== e_lg || bus.mem_en !== (e_fg || e_lg) ||
          bus.mem_we !== (e_lg && bus.l_we)) begin
        n_err++;
        $display("FAIL rand_grant cyc=%0d: f/l/en/we=%b%b%b%b expected %b%b%b%b", cyc,
                 bus.f_gnt, bus.l_gnt, bus.mem_en, bus.mem_we, e_fg, e_lg, e_fg || e_lg, e_lg && bus.l_we);
      end
      n_cmp++;
      if (bus.mem_addr !== e_addr || bus.mem_wdata !== e_wdata) begin
        n_err++;
        $display("FAIL rand_bus cyc=%0d: addr=%h wdata=%h expected %h %h", cyc,
                 bus.mem_addr, bus.mem_wdata, e_addr, e_wdata);
      end
      n_cmp++;
      if (bus.f_rvalid !== e_frv || bus.f_rdata !== e_frd ||
          bus.l_rvalid !== e_lrv || bus.l_rdata !== e_lrd) begin
        n_err++;
        $display("FAIL rand_resp cyc=%0d: f %b %h l %b %h expected f %b %h l %b %h", cyc,
                 bus.f_rvalid, bus.f_rdata, bus.l_rvalid, bus.l_rdata, e_frv, e_frd, e_lrv, e_lrd);
      end
      // advance the model past the clock edge
      pend_kind = 0;
      if (e_lg && !bus.l_we) begin
        pend_kind = 2;
        pend_data = shadow[bus.l_addr];
      end else if (e_fg) begin
        pend_kind = 1;
        pend_data = shadow[bus.f_addr];
      end
      if (e_lg && bus.l_we) shadow[bus.l_addr] = bus.l_wdata;
      if (bus.l_req && !e_lg) denied = (denied < SMAX) ? denied + 1 : SMAX;
      else                    denied = 0;
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    test_reset();
    test_fetch_burst();
    test_loader();
    test_flush();
    test_priority();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
